pll_lock_mgr: RTL and testbench
===============================

Name: pll_lock_mgr

Overview:
- Supervises the fabric rPLL fed by the 50 MHz board clock.
- Sequences PLL reset, waits for and debounces LOCK, retries on timeout, and releases the downstream system reset only once the clock is stable.
- Owns the PLL dynamic phase (PSDA) and duty (DUTYDA) inputs and applies requester updates through a req/ack handshake.
- Runs on the PLL input clock, never on a PLL output.

Parameters:
RST_CYCLES, 16, cycles pll_reset is held high per attempt (>=1)
LOCK_STABLE, 1024, consecutive synced-lock-high cycles required before RUN
LOCK_TIMEOUT, 65536, cycles allowed from pll_reset release to reaching RUN
MAX_RETRY, 3, failed attempts before sticky FAIL
SETTLE_CYCLES, 8, cycles to hold after a PSDA/DUTYDA change before ack

Ports:
clk  in  1  50 MHz reference clock, the same net as PLL clkin
rst_n  in  1  asynchronous active-low reset
pll_lock  in  1  PLL LOCK, asynchronous, synchronised internally
pll_reset  out  1  to PLL RESET, active high
pll_psda  out  4  to PLL PSDA
pll_dutyda  out  4  to PLL DUTYDA
cfg_req  in  1  level request; held high until cfg_ack
cfg_psda  in  4  requested phase code, sampled on acceptance
cfg_dutyda  in  4  requested duty code, sampled on acceptance
cfg_ack  out  1  one-cycle pulse when the new setting has settled
sys_rst_n  out  1  downstream reset, active low, registered
pll_ready  out  1  high in RUN and APPLY
pll_fail  out  1  sticky failure flag
retry_cnt  out  2  failed attempts so far (saturates at MAX_RETRY)

Behaviour:
- Reset values while rst_n is low:
  - State RST_PLL, pll_reset=1, sys_rst_n=0, pll_ready=0, pll_fail=0, cfg_ack=0, retry_cnt=0.
  - pll_psda=4'b0000, pll_dutyda=4'b1000.
  - All counters 0.
- Lock input: pll_lock passes through a 2-flop synchroniser; lock_s lags pll_lock by 2 cycles.
- RST_PLL:
  - pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with pll_reset=0.
  - Timeout counter cleared.
- WAIT_LOCK:
  - Timeout counter increments every cycle.
  - lock_s=1 -> STABLE with the stable counter cleared.
- STABLE:
  - Stable counter increments while lock_s=1.
  - lock_s=0 -> back to WAIT_LOCK; the timeout counter keeps running and the stable counter clears.
  - Stable count reaches LOCK_STABLE-1 with lock_s=1 -> RUN.
- Timeout, in WAIT_LOCK or STABLE, when the timeout counter reaches LOCK_TIMEOUT-1:
  - retry_cnt increments.
  - If the new value equals MAX_RETRY -> FAIL, otherwise -> RST_PLL.
  - Timeout takes priority over a simultaneous STABLE completion.
- RUN:
  - sys_rst_n=1 and pll_ready=1, both registered, first high in the first RUN cycle.
  - retry_cnt clears on entry.
  - lock_s=0 -> RST_PLL; sys_rst_n and pll_ready drop the same cycle the state changes. PSDA/DUTYDA keep their current values.
  - cfg_req=1 -> latch cfg_psda/cfg_dutyda into pll_psda/pll_dutyda, go to APPLY.
- APPLY:
  - Hold for SETTLE_CYCLES; sys_rst_n stays 1.
  - At completion, pulse cfg_ack for 1 cycle and return to RUN.
  - lock_s=0 during APPLY -> RST_PLL with no ack; the request remains pending and is served after relock.
  - A re-entry to APPLY is blocked for the ack cycle, so a requester dropping req after ack is never double-served.
- FAIL:
  - pll_reset=1, sys_rst_n=0, pll_fail=1.
  - Exits only on rst_n.
- cfg_req outside RUN is ignored and not acked; there is no queueing.
- Counter widths: $clog2 of the largest count, +1 bit. No wrap is possible because every counter is cleared on state entry.

Decomposition:
- pll_mgr_pkg holds:
  - the state enum (RST_PLL, WAIT_LOCK, STABLE, RUN, APPLY, FAIL);
  - PSDA_DEFAULT=4'b0000 and DUTYDA_DEFAULT=4'b1000.
- One sub-module, sync_2ff (1-bit, async active-low reset to 0), used for pll_lock.

Test Plan:
Use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, MAX_RETRY=2, SETTLE_CYCLES=4 throughout.
1. Release rst_n; pll_lock rises 10 cycles later and stays high -> pll_reset high exactly 4 cycles; sys_rst_n/pll_ready rise 2+8 cycles after pll_lock rises; retry_cnt=0.
2. Lock glitches low for 1 cycle mid-STABLE -> stable count restarts; RUN is reached 8 cycles after the synced glitch ends.
3. pll_lock held at 0 -> two 4-cycle pll_reset pulses 64 cycles apart, then pll_fail=1 and sys_rst_n=0 held; retry_cnt=2; only rst_n clears the fail.
4. In RUN, cfg_req=1 with cfg_psda=4'h3 and cfg_dutyda=4'h6 -> pll_psda=3 and pll_dutyda=6 the next cycle; single cfg_ack 4 cycles later; sys_rst_n never drops.
5. Lock dropped during APPLY -> sys_rst_n falls, pll_reset pulses, no ack; req still held; after relock and RUN, the request is served and acked once.
6. rst_n asserted in RUN mid-operation -> all outputs at reset values immediately; psda=0 and dutyda=8.

Source files
------------

// File: rtl/pll_mgr_pkg.sv
// Shared types and reset defaults for the PLL lock manager.
`timescale 1ns/1ps
package pll_mgr_pkg;

  localparam int unsigned CODE_W = 4;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    APPLY     = 3'd4,
    FAIL      = 3'd5
  } state_e;

  localparam logic [CODE_W-1:0] PSDA_DEFAULT   = 4'b0000;
  localparam logic [CODE_W-1:0] DUTYDA_DEFAULT = 4'b1000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_mgr.sv
// PLL supervisor: reset sequencing, lock debounce with retry, system reset
// release and handshaked PSDA/DUTYDA updates. Clocked by the PLL reference.
`timescale 1ns/1ps
module pll_lock_mgr
  import pll_mgr_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE   = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda,
  input  logic       cfg_req,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  output logic       cfg_ack,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [1:0] retry_cnt
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned TMO_W   = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned STB_W   = $clog2(LOCK_STABLE) + 1;

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [STB_W-1:0]  stb_q, stb_d;
  logic [1:0]        retry_q, retry_d;
  logic [CODE_W-1:0] psda_q, psda_d;
  logic [CODE_W-1:0] duty_q, duty_d;
  logic              ack_q, ack_d;
  logic              pll_reset_q, pll_reset_d;
  logic              sys_rst_n_q, sys_rst_n_d;
  logic              ready_q, ready_d;
  logic              fail_q, fail_d;

  logic              timeout_c;
  logic [1:0]        retry_inc_c;
  logic [STB_W-1:0]  stb_inc_c;

  assign timeout_c   = (tmo_q == TMO_W'(LOCK_TIMEOUT - 1));
  assign retry_inc_c = retry_q + 2'd1;
  assign stb_inc_c   = stb_q + STB_W'(1);

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    stb_d   = stb_q;
    retry_d = retry_q;
    psda_d  = psda_q;
    duty_d  = duty_q;
    ack_d   = 1'b0;

    unique case (state_q)
      RST_PLL: begin
        tmo_d = '0;
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LOCK, STABLE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (timeout_c) begin
          retry_d = retry_inc_c;
          cnt_d   = '0;
          state_d = (retry_inc_c == 2'(MAX_RETRY)) ? FAIL : RST_PLL;
        end else if (state_q == WAIT_LOCK) begin
          if (lock_s) begin
            state_d = STABLE;
            stb_d   = '0;
          end
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
          stb_d   = '0;
        end else begin
          // The WAIT_LOCK cycle that saw lock counts as the first stable cycle
          stb_d = stb_inc_c;
          if (stb_inc_c == STB_W'(LOCK_STABLE - 1)) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = RST_PLL;
          cnt_d   = '0;
        end else if (cfg_req && !ack_q) begin
          // ack_q blocks the request still visible in the ack cycle
          state_d = APPLY;
          cnt_d   = '0;
          psda_d  = cfg_psda;
          duty_d  = cfg_dutyda;
        end
      end
      APPLY: begin
        if (!lock_s) begin
          state_d = RST_PLL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = RUN;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RST_PLL;
        cnt_d   = '0;
      end
    endcase

    pll_reset_d = (state_d == RST_PLL) || (state_d == FAIL);
    sys_rst_n_d = (state_d == RUN) || (state_d == APPLY);
    ready_d     = (state_d == RUN) || (state_d == APPLY);
    fail_d      = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_PLL;
      cnt_q       <= '0;
      tmo_q       <= '0;
      stb_q       <= '0;
      retry_q     <= '0;
      psda_q      <= PSDA_DEFAULT;
      duty_q      <= DUTYDA_DEFAULT;
      ack_q       <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      stb_q       <= stb_d;
      retry_q     <= retry_d;
      psda_q      <= psda_d;
      duty_q      <= duty_d;
      ack_q       <= ack_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset  = pll_reset_q;
  assign pll_psda   = psda_q;
  assign pll_dutyda = duty_q;
  assign cfg_ack    = ack_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign pll_ready  = ready_q;
  assign pll_fail   = fail_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Directed bench for pll_lock_mgr; cfg acks are checked against a scoreboard.
`timescale 1ns/1ps
module tb_pll_lock_mgr;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_STABLE   = 8;
  localparam int unsigned LOCK_TIMEOUT  = 64;
  localparam int unsigned MAX_RETRY     = 2;
  localparam int unsigned SETTLE_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       cfg_req = 1'b0;
  logic [3:0] cfg_psda = 4'h0;
  logic [3:0] cfg_dutyda = 4'h0;
  logic       pll_reset;
  logic [3:0] pll_psda;
  logic [3:0] pll_dutyda;
  logic       cfg_ack;
  logic       sys_rst_n;
  logic       pll_ready;
  logic       pll_fail;
  logic [1:0] retry_cnt;

  pll_lock_mgr #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_STABLE   (LOCK_STABLE),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .MAX_RETRY     (MAX_RETRY),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_psda   (pll_psda),
    .pll_dutyda (pll_dutyda),
    .cfg_req    (cfg_req),
    .cfg_psda   (cfg_psda),
    .cfg_dutyda (cfg_dutyda),
    .cfg_ack    (cfg_ack),
    .sys_rst_n  (sys_rst_n),
    .pll_ready  (pll_ready),
    .pll_fail   (pll_fail),
    .retry_cnt  (retry_cnt)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] psda;
    logic [3:0] duty;
    int         at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, 32'(pll_reset), 1);
    chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
    chk({tag, "_ready"}, 32'(pll_ready), 0);
    chk({tag, "_fail"}, 32'(pll_fail), 0);
    chk({tag, "_ack"}, 32'(cfg_ack), 0);
    chk({tag, "_retry"}, 32'(retry_cnt), 0);
    chk({tag, "_psda"}, 32'(pll_psda), 0);
    chk({tag, "_dutyda"}, 32'(pll_dutyda), 8);
  endtask

  // Every ack must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && cfg_ack) begin
      chk("ack_pending", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_psda", 32'(pll_psda), 32'(e.psda));
        chk("ack_dutyda", 32'(pll_dutyda), 32'(e.duty));
        chk("ack_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int   hi, n, drops;
  int   f1, r1, f2, r2, fa, r100;
  logic prev;

  initial begin
    // Reset state
    tick(3);
    chk_reset_vals("rst");

    // 1: clean lock-up
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (pll_reset) hi++;
      tick(1);
    end
    chk("rst_pulse_len", 32'(hi), 4);
    pll_lock = 1'b1;
    n = 0;
    while (!sys_rst_n && n < 200) begin tick(1); n++; end
    chk("lock_to_run", 32'(n), 10);
    chk("run_ready", 32'(pll_ready), 1);
    chk("run_retry", 32'(retry_cnt), 0);
    chk("run_pll_reset", 32'(pll_reset), 0);

    // 2: one-cycle lock glitch while debouncing
    rst_n = 1'b0; pll_lock = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    pll_lock = 1'b1;
    tick(4);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(5);
    chk("glitch_no_run_yet", 32'(sys_rst_n), 0);
    chk("glitch_no_pll_reset", 32'(pll_reset), 0);
    n = 0;
    while (!sys_rst_n && n < 200) begin tick(1); n++; end
    chk("glitch_to_run", 32'(n), 5);

    // 4: phase/duty update in RUN
    cfg_psda = 4'h3; cfg_dutyda = 4'h6; cfg_req = 1'b1;
    sb.push_back('{4'h3, 4'h6, cyc + 1 + int'(SETTLE_CYCLES)});
    tick(1);
    chk("apply_psda", 32'(pll_psda), 3);
    chk("apply_dutyda", 32'(pll_dutyda), 6);
    chk("apply_ready", 32'(pll_ready), 1);
    drops = 0; n = 0;
    while (!cfg_ack && n < 20) begin
      if (!sys_rst_n) drops++;
      tick(1); n++;
    end
    chk("ack_latency", 32'(n), 4);
    tick(1);
    cfg_req = 1'b0;
    tick(6);
    chk("apply_no_sysrst_drop", 32'(drops), 0);
    chk("apply_sysrst_hi", 32'(sys_rst_n), 1);
    chk("sb_empty_apply", 32'(sb.size()), 0);

    // 5: lock lost during APPLY, request served after relock
    cfg_psda = 4'hA; cfg_dutyda = 4'h5; cfg_req = 1'b1;
    sb.push_back('{4'hA, 4'h5, cyc + 21});
    tick(1);
    pll_lock = 1'b0;
    chk("lost_psda_latched", 32'(pll_psda), 10);
    tick(3);
    chk("lost_sys_rst_n", 32'(sys_rst_n), 0);
    chk("lost_pll_reset", 32'(pll_reset), 1);
    chk("lost_ready", 32'(pll_ready), 0);
    chk("lost_psda_kept", 32'(pll_psda), 10);
    chk("lost_dutyda_kept", 32'(pll_dutyda), 5);
    pll_lock = 1'b1;
    n = 0;
    while (!cfg_ack && n < 60) begin tick(1); n++; end
    chk("relock_ack_wait", 32'(n), 17);
    chk("relock_sysrst", 32'(sys_rst_n), 1);
    cfg_req = 1'b0;
    tick(5);
    chk("sb_empty_relock", 32'(sb.size()), 0);
    chk("relock_retry", 32'(retry_cnt), 0);

    // 6: async reset in RUN
    tick(3);
    chk("pre_rst_run", 32'(sys_rst_n), 1);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    pll_lock = 1'b0;
    tick(2);

    // 3: no lock -> two attempts then sticky FAIL
    rst_n = 1'b1;
    f1 = -1; r1 = -1; f2 = -1; r2 = -1; fa = -1; r100 = -1;
    prev = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (prev && !pll_reset) begin
        if (f1 < 0) f1 = i; else if (f2 < 0) f2 = i;
      end
      if (!prev && pll_reset) begin
        if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
      end
      if (pll_fail && fa < 0) fa = i;
      if (i == 100) r100 = int'(retry_cnt);
      prev = pll_reset;
      tick(1);
    end
    chk("to_fall1", 32'(f1), 4);
    chk("to_rise1", 32'(r1), 68);
    chk("to_fall2", 32'(f2), 72);
    chk("to_rise2", 32'(r2), 136);
    chk("to_fail_at", 32'(fa), 136);
    chk("to_retry_mid", 32'(r100), 1);
    chk("fail_retry", 32'(retry_cnt), 2);
    chk("fail_flag", 32'(pll_fail), 1);
    chk("fail_sysrst", 32'(sys_rst_n), 0);
    chk("fail_pll_reset", 32'(pll_reset), 1);
    pll_lock = 1'b1;
    tick(40);
    chk("fail_sticky", 32'(pll_fail), 1);
    chk("fail_sticky_sysrst", 32'(sys_rst_n), 0);
    rst_n = 1'b0;
    tick(1);
    chk("fail_cleared", 32'(pll_fail), 0);
    chk("fail_retry_cleared", 32'(retry_cnt), 0);
    chk("sb_empty_end", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
